// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_e;

    // Access size in bytes comes only from the low two funct3 bits.
    function automatic logic [2:0] f3_size(logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(logic we, logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_cross(logic [1:0] sz, logic [1:0] off);
        logic [3:0] w_end;
        w_end = {2'b00, off} + {1'b0, f3_size(sz)};
        return w_end > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane unit: byte enables, lane-shifted store data,
// two-word load merge and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata0,
    input  logic [23:0] i_rdata1,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wd0,
    output logic [31:0] o_wd1,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_mask;
    logic [7:0]  w_be64;
    logic [31:0] w_raw;

    always_comb begin
        case (f3_size(i_funct3[1:0]))
            3'd1:    w_mask = 8'h01;
            3'd2:    w_mask = 8'h03;
            default: w_mask = 8'h0F;
        endcase
        w_be64 = w_mask << i_off;
        o_be0  = w_be64[3:0];
        o_be1  = w_be64[7:4];
    end

    // Bytes pushed past lane 3 of the first word land in the second word.
    always_comb begin
        o_wd0 = i_wdata << {i_off, 3'b000};
        case (i_off)
            2'd1:    o_wd1 = {24'b0, i_wdata[31:24]};
            2'd2:    o_wd1 = {16'b0, i_wdata[31:16]};
            2'd3:    o_wd1 = {8'b0, i_wdata[31:8]};
            default: o_wd1 = 32'b0;
        endcase
    end

    always_comb begin
        case (i_off)
            2'd1:    w_raw = {i_rdata1[7:0],  i_rdata0[31:8]};
            2'd2:    w_raw = {i_rdata1[15:0], i_rdata0[31:16]};
            2'd3:    w_raw = {i_rdata1[23:0], i_rdata0[31:24]};
            default: w_raw = i_rdata0;
        endcase
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_raw[7]}}, w_raw[7:0]};
            F3_H:    o_rdata = {{16{w_raw[15]}}, w_raw[15:0]};
            F3_BU:   o_rdata = {24'b0, w_raw[7:0]};
            F3_HU:   o_rdata = {16'b0, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: captures one MEM-stage request, issues one or two
// word-aligned bus transactions and returns merged/extended load data.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int SPLIT_EN = 1
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busy,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    state_e      r_state;
    state_e      w_next;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata0;
    logic [23:0] r_rdata1;

    logic        w_accept;
    logic        w_req_err;
    logic        w_cross;
    logic [31:0] w_addr0;
    logic [3:0]  w_be0;
    logic [3:0]  w_be1;
    logic [31:0] w_wd0;
    logic [31:0] w_wd1;
    logic [31:0] w_ext;

    assign w_accept  = i_req_valid && (r_state == S_IDLE);
    assign w_req_err = !f3_legal(i_req_we, i_req_funct3) ||
                       ((SPLIT_EN == 0) && f3_cross(i_req_funct3[1:0], i_req_addr[1:0]));
    assign w_cross   = f3_cross(r_f3[1:0], r_addr[1:0]);
    assign w_addr0   = {r_addr[31:2], 2'b00};

    lsu_align u_align (
        .i_funct3 (r_f3),
        .i_off    (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata0 (r_rdata0),
        .i_rdata1 (r_rdata1),
        .o_be0    (w_be0),
        .o_be1    (w_be1),
        .o_wd0    (w_wd0),
        .o_wd1    (w_wd1),
        .o_rdata  (w_ext)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Second-word data is cleared at acceptance so single-word loads merge with zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we     <= 1'b0;
            r_f3     <= 3'b000;
            r_addr   <= 32'b0;
            r_wdata  <= 32'b0;
            r_err    <= 1'b0;
            r_rdata0 <= 32'b0;
            r_rdata1 <= 24'b0;
        end else begin
            if (w_accept) begin
                r_we     <= i_req_we;
                r_f3     <= i_req_funct3;
                r_addr   <= i_req_addr;
                r_wdata  <= i_req_wdata;
                r_err    <= w_req_err;
                r_rdata0 <= 32'b0;
                r_rdata1 <= 24'b0;
            end
            if ((r_state == S_WAIT0) && i_mem_rvalid)
                r_rdata0 <= i_mem_rdata;
            if ((r_state == S_WAIT1) && i_mem_rvalid)
                r_rdata1 <= i_mem_rdata[23:0];
        end
    end

    always_comb begin
        w_next      = r_state;
        o_mem_req   = 1'b0;
        o_mem_addr  = 32'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'b0;
        o_mem_wdata = 32'b0;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = 32'b0;
        o_req_ready = (r_state == S_IDLE);
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_req_valid)
                    w_next = w_req_err ? S_RESP : S_REQ0;
            end
            S_REQ0: begin
                o_mem_req   = 1'b1;
                o_mem_addr  = w_addr0;
                o_mem_we    = r_we;
                o_mem_be    = w_be0;
                o_mem_wdata = w_wd0;
                if (i_mem_gnt)
                    w_next = S_WAIT0;
            end
            S_WAIT0: begin
                if (i_mem_rvalid)
                    w_next = w_cross ? S_REQ1 : S_RESP;
            end
            S_REQ1: begin
                o_mem_req   = 1'b1;
                o_mem_addr  = w_addr0 + 32'd4;
                o_mem_we    = r_we;
                o_mem_be    = w_be1;
                o_mem_wdata = w_wd1;
                if (i_mem_gnt)
                    w_next = S_WAIT1;
            end
            S_WAIT1: begin
                if (i_mem_rvalid)
                    w_next = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = r_err;
                o_rsp_rdata = (r_err || r_we) ? 32'b0 : w_ext;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a byte-addressed memory model.
module tb_lsu_ctrl;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid, reqReady, reqWe;
    logic [2:0]  reqF3;
    logic [31:0] reqAddr, reqWdata;
    logic        rspValid, rspErr, busy;
    logic [31:0] rspRdata;
    logic        memReq, memGnt, memWe, memRvalid;
    logic [31:0] memAddr, memWdata, memRdata;
    logic [3:0]  memBe;

    int checks = 0;
    int errors = 0;

    logic [31:0] memWord [logic [29:0]];
    logic [7:0]  refMem [logic [31:0]];
    txn_t        txnLog [$];
    bit          randomDelays = 1'b0;
    int          gntDelayCfg = 0;
    int          rvDelayCfg = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_we     (reqWe),
        .i_req_funct3 (reqF3),
        .i_req_addr   (reqAddr),
        .i_req_wdata  (reqWdata),
        .o_rsp_valid  (rspValid),
        .o_rsp_rdata  (rspRdata),
        .o_rsp_err    (rspErr),
        .o_busy       (busy),
        .o_mem_req    (memReq),
        .i_mem_gnt    (memGnt),
        .o_mem_addr   (memAddr),
        .o_mem_we     (memWe),
        .o_mem_be     (memBe),
        .o_mem_wdata  (memWdata),
        .i_mem_rvalid (memRvalid),
        .i_mem_rdata  (memRdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] initWord(logic [29:0] idx);
        return ({idx, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] busRead(logic [29:0] idx);
        return memWord.exists(idx) ? memWord[idx] : initWord(idx);
    endfunction

    function automatic logic [7:0] refByte(logic [31:0] a);
        logic [31:0] w;
        if (refMem.exists(a))
            return refMem[a];
        w = initWord(a[31:2]);
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic setWord(input logic [31:0] addr, input logic [31:0] val);
        memWord[addr[31:2]] = val;
        for (int i = 0; i < 4; i++)
            refMem[{addr[31:2], 2'b00} + i] = val[8*i +: 8];
    endtask

    // Bus slave: grants after a configurable delay, acks one or more cycles later.
    initial begin
        bit          reqSeen = 1'b0;
        bit          rvPending = 1'b0;
        int          gntWait = 0;
        int          rvWait = 0;
        logic [31:0] rvData = 32'b0;
        logic [31:0] w;
        txn_t        snap;
        memGnt = 1'b0;
        memRvalid = 1'b0;
        memRdata = 32'b0;
        forever begin
            @(negedge clk);
            memGnt = 1'b0;
            memRvalid = 1'b0;
            memRdata = $urandom;
            if (rst) begin
                reqSeen = 1'b0;
            end else if (rvPending) begin
                if (rvWait == 0) begin
                    memRvalid = 1'b1;
                    memRdata = rvData;
                    rvPending = 1'b0;
                end else begin
                    rvWait--;
                end
            end else if (memReq) begin
                if (!reqSeen) begin
                    reqSeen = 1'b1;
                    snap.addr = memAddr;
                    snap.be = memBe;
                    snap.we = memWe;
                    snap.wdata = memWdata;
                    gntWait = randomDelays ? int'($urandom_range(0, 3)) : gntDelayCfg;
                end else begin
                    checkOutput("stableAddr", memAddr, snap.addr);
                    checkOutput("stableBe", {28'b0, memBe}, {28'b0, snap.be});
                    checkOutput("stableWe", {31'b0, memWe}, {31'b0, snap.we});
                    checkOutput("stableWdata", memWdata, snap.wdata);
                end
                if (gntWait == 0) begin
                    memGnt = 1'b1;
                    reqSeen = 1'b0;
                    txnLog.push_back(snap);
                    if (snap.we) begin
                        w = busRead(snap.addr[31:2]);
                        for (int b = 0; b < 4; b++)
                            if (snap.be[b]) w[8*b +: 8] = snap.wdata[8*b +: 8];
                        memWord[snap.addr[31:2]] = w;
                    end
                    rvData = snap.we ? $urandom : busRead(snap.addr[31:2]);
                    rvPending = 1'b1;
                    rvWait = randomDelays ? int'($urandom_range(0, 2)) : rvDelayCfg;
                end else begin
                    gntWait--;
                end
            end
        end
    end

    // One request end to end; expectations come from byte-level access rules.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit checkLat,
                                 output logic [31:0] rdataOut);
        int          size, off, nTx, lat, pos, expLat;
        bit          legal, got, ready;
        logic [31:0] expData, a;
        logic [3:0]  expBe [2];
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        off   = int'(addr[1:0]);
        nTx   = !legal ? 0 : (off + size > 4) ? 2 : 1;
        expData = 32'b0;
        if (legal && !we) begin
            for (int i = 0; i < size; i++) begin
                a = addr + i;
                expData = expData | ({24'b0, refByte(a)} << (8 * i));
            end
            if (f3 == 3'd0) expData = {{24{expData[7]}}, expData[7:0]};
            if (f3 == 3'd1) expData = {{16{expData[15]}}, expData[15:0]};
        end
        expBe[0] = 4'b0;
        expBe[1] = 4'b0;
        for (int i = 0; i < size; i++) begin
            pos = off + i;
            expBe[pos / 4][pos % 4] = 1'b1;
        end

        ready = 1'b0;
        for (int i = 0; i < 100 && !ready; i++) begin
            @(negedge clk);
            ready = reqReady;
        end
        checkOutput("reqReady", {31'b0, ready}, 32'd1);
        txnLog.delete();
        reqValid = 1'b1;
        reqWe = we;
        reqF3 = f3;
        reqAddr = addr;
        reqWdata = wdata;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqWe = $urandom;
        reqF3 = $urandom;
        reqAddr = $urandom;
        reqWdata = $urandom;

        lat = 0;
        got = 1'b0;
        while (lat < 300 && !got) begin
            @(negedge clk);
            lat++;
            if (lat == 1) checkOutput("busyAfterAccept", {31'b0, busy}, 32'd1);
            got = rspValid;
        end
        checkOutput("rspSeen", {31'b0, got}, 32'd1);
        rdataOut = rspRdata;
        if (got) begin
            checkOutput("rspErr", {31'b0, rspErr}, {31'b0, !legal});
            checkOutput("rspRdata", rspRdata, expData);
            checkOutput("txnCount", txnLog.size(), nTx);
            if (checkLat) begin
                expLat = !legal ? 1 : (nTx == 1) ? 3 : 5;
                checkOutput("latency", lat, expLat);
            end
            for (int k = 0; k < txnLog.size() && k < nTx; k++) begin
                checkOutput("txnAddr", txnLog[k].addr, {addr[31:2], 2'b00} + 32'(4 * k));
                checkOutput("txnBe", {28'b0, txnLog[k].be}, {28'b0, expBe[k]});
                checkOutput("txnWe", {31'b0, txnLog[k].we}, {31'b0, we});
            end
            if (we && legal && txnLog.size() == nTx) begin
                for (int i = 0; i < size; i++) begin
                    pos = off + i;
                    checkOutput("laneData", {24'b0, txnLog[pos / 4].wdata[8*(pos % 4) +: 8]},
                                {24'b0, wdata[8*i +: 8]});
                end
            end
        end
        if (legal && we)
            for (int i = 0; i < size; i++)
                refMem[addr + i] = wdata[8*i +: 8];
        @(negedge clk);
        checkOutput("rspPulse", {31'b0, rspValid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] base;
        int          pulses;
        bit          seen;
        logic [2:0]  f3;
        rst = 1'b1;
        reqValid = 1'b0;
        reqWe = 1'b0;
        reqF3 = 3'b0;
        reqAddr = 32'b0;
        reqWdata = 32'b0;
        #1;
        checkOutput("rstReady", {31'b0, reqReady}, 32'd1);
        checkOutput("rstMemReq", {31'b0, memReq}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstRspValid", {31'b0, rspValid}, 32'd0);
        checkOutput("rstRspErr", {31'b0, rspErr}, 32'd0);
        checkOutput("rstRspRdata", rspRdata, 32'd0);
        checkOutput("rstMemAddr", memAddr, 32'd0);
        checkOutput("rstMemBe", {28'b0, memBe}, 32'd0);
        checkOutput("rstMemWe", {31'b0, memWe}, 32'd0);
        checkOutput("rstMemWdata", memWdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed cases");
        setWord(32'h100, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, r);
        checkOutput("t1Lw", r, 32'hDEADBEEF);

        setWord(32'h100, 32'h80112233);
        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, r);
        checkOutput("t2Lb", r, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 1'b1, r);
        checkOutput("t2Lbu", r, 32'h00000080);
        applyStimulus(1'b0, 3'b101, 32'h102, 32'h0, 1'b1, r);
        checkOutput("t2Lhu", r, 32'h00008011);

        setWord(32'h100, 32'h11223344);
        setWord(32'h104, 32'h55667788);
        applyStimulus(1'b0, 3'b010, 32'h102, 32'h0, 1'b1, r);
        checkOutput("t3LwSplit", r, 32'h77881122);

        applyStimulus(1'b1, 3'b001, 32'h103, 32'h0000ABCD, 1'b1, r);
        if (txnLog.size() == 2) begin
            checkOutput("t4Be0", {28'b0, txnLog[0].be}, 32'h8);
            checkOutput("t4Byte0", {24'b0, txnLog[0].wdata[31:24]}, 32'hCD);
            checkOutput("t4Addr1", txnLog[1].addr, 32'h104);
            checkOutput("t4Be1", {28'b0, txnLog[1].be}, 32'h1);
            checkOutput("t4Byte1", {24'b0, txnLog[1].wdata[7:0]}, 32'hAB);
        end else begin
            checkOutput("t4TxnCount", txnLog.size(), 32'd2);
        end

        applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, r);
        applyStimulus(1'b1, 3'b100, 32'h100, 32'h1234, 1'b1, r);
        setWord(32'hFFFFFFFC, 32'hCAFEF00D);
        setWord(32'h0, 32'h01234567);
        gntDelayCfg = 5;
        applyStimulus(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b0, r);
        checkOutput("t5WrapData", r, 32'h4567CAFE);
        if (txnLog.size() == 2) checkOutput("t5WrapAddr", txnLog[1].addr, 32'h0);
        gntDelayCfg = 0;

        // Abort a split load while waiting for its second ack.
        rvDelayCfg = 4;
        txnLog.delete();
        @(negedge clk);
        reqValid = 1'b1;
        reqWe = 1'b0;
        reqF3 = 3'b010;
        reqAddr = 32'h102;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (txnLog.size() == 2);
        end
        checkOutput("t6SecondGnt", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6MemReq", {31'b0, memReq}, 32'd0);
        checkOutput("t6Busy", {31'b0, busy}, 32'd0);
        checkOutput("t6Ready", {31'b0, reqReady}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rspValid) pulses++;
        end
        checkOutput("t6NoRsp", pulses, 32'd0);
        checkOutput("t6IdleBusy", {31'b0, busy}, 32'd0);
        rvDelayCfg = 0;
        setWord(32'h100, 32'h0BADF00D);
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 1'b1, r);
        checkOutput("t6Recover", r, 32'h0BADF00D);

        $display("[TB] random traffic");
        randomDelays = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0:       base = 32'h100;
                1:       base = 32'hFFFFFFF0;
                default: base = 32'h0;
            endcase
            f3 = 3'($urandom_range(0, 7));
            applyStimulus(1'($urandom), f3, base + 32'($urandom_range(0, 15)), $urandom, 1'b0, r);
        end

        foreach (memWord[idx]) begin
            for (int b = 0; b < 4; b++) begin
                r = memWord[idx];
                checkOutput("memByte", {24'b0, r[8*b +: 8]}, {24'b0, refByte({idx, 2'b00} + b)});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
